// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: instruction field layout,
// the HALT encoding and the sequencer state encoding.
package instr_issuer_pkg;

  localparam int WSEL_W = 2;
  localparam int RSEL_W = 2;
  localparam int DATA_W = 8;
  localparam int OP_W   = 1;

  // Field order, MSB first: {wsel, rsel, data, op}.
  typedef struct packed {
    logic [WSEL_W-1:0] wsel;
    logic [RSEL_W-1:0] rsel;
    logic [DATA_W-1:0] data;
    logic [OP_W-1:0]   op;
  } instr_t;

  localparam int INSTR_W  = $bits(instr_t);
  localparam int WSEL_LSB = INSTR_W - WSEL_W;

  // A wsel of all ones stops the run instead of writing back.
  localparam logic [WSEL_W-1:0] HALT_WSEL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/instr_issuer_prog_mem.sv
// Program store: synchronous write, asynchronous read. Not reset, so a
// program survives a reset of the sequencer.
module prog_mem #(
  parameter  int DEPTH = 16,
  parameter  int IW    = 13,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_ck,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [IW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [IW-1:0] o_rdata
);

  logic [IW-1:0] r_mem [DEPTH];

  // Write port; gating against running programs is done by the caller.
  always_ff @(posedge i_ck) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_issuer.sv
// Instruction issuer: steps through program memory from entry 0 to a latched
// last index, presenting each word for three cycles (setup, write strobe,
// hold) to the register/ALU datapath. HALT words and abort end runs early.
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int IW    = 13,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          ck,
  input  logic          clr_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic [AW-1:0] last,
  input  logic          start,
  input  logic          abort,
  output logic [IW-1:0] instr,
  output logic          sel_en,
  output logic          alu_en,
  output logic          wr_stb,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  logic          r_start_q;
  logic [AW-1:0] r_last_q;
  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_instr;
  logic          r_sel_en;
  logic          r_alu_en;
  logic          r_wr_stb;
  logic          r_busy;
  logic          r_done;

  logic          w_start_rise;
  logic          w_mem_we;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_rd_addr;
  logic [IW-1:0] w_rd_data;
  logic          w_halt;

  assign w_start_rise = start & ~r_start_q;
  // Program may only change while nothing is being issued.
  assign w_mem_we     = prog_we & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_pc_inc     = r_pc + AW'(1);
  // instr is loaded on entry to SETUP: entry 0 from IDLE, pc+1 from HOLD.
  assign w_rd_addr    = (r_state == ST_HOLD) ? w_pc_inc : '0;
  // r_instr holds mem[pc] throughout SETUP, so it is the word to test.
  assign w_halt       = (r_instr[WSEL_LSB +: WSEL_W] == HALT_WSEL);

  prog_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
    .i_ck    (ck),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // Previous start level, for rising-edge detection.
  always_ff @(posedge ck) begin
    if (!clr_n) r_start_q <= 1'b0;
    else        r_start_q <= start;
  end

  // Sequencer: state, pc and all outputs registered together so outputs
  // always describe the current state.
  always_ff @(posedge ck) begin
    if (!clr_n) begin
      r_state  <= ST_IDLE;
      r_last_q <= '0;
      r_pc     <= '0;
      r_instr  <= '0;
      r_sel_en <= 1'b0;
      r_alu_en <= 1'b0;
      r_wr_stb <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      if (abort && r_busy) begin
        // Abort wins over HALT and last checks; a strobe already showing
        // this cycle has completed, nothing new is started.
        r_state  <= ST_IDLE;
        r_pc     <= '0;
        r_instr  <= '0;
        r_sel_en <= 1'b0;
        r_alu_en <= 1'b0;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_start_rise && !prog_we) begin
              r_state  <= ST_SETUP;
              r_pc     <= '0;
              r_last_q <= last;
              r_instr  <= w_rd_data;
              r_sel_en <= 1'b1;
              r_alu_en <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
          ST_SETUP: begin
            if (w_halt) begin
              r_state  <= ST_DONE;
              r_sel_en <= 1'b0;
              r_alu_en <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state  <= ST_STROBE;
              r_wr_stb <= 1'b1;
            end
          end
          ST_STROBE: r_state <= ST_HOLD;
          ST_HOLD: begin
            if (r_pc == r_last_q) begin
              r_state  <= ST_DONE;
              r_sel_en <= 1'b0;
              r_alu_en <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_state  <= ST_SETUP;
              r_pc     <= w_pc_inc;
              r_instr  <= w_rd_data;
            end
          end
          ST_DONE: begin
            if (!start) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign instr  = r_instr;
  assign sel_en = r_sel_en;
  assign alu_en = r_alu_en;
  assign wr_stb = r_wr_stb;
  assign pc     = r_pc;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: a per-cycle vector table for normal,
// multi-instruction and HALT runs, plus hand sequences for abort, blocked
// writes, mid-run reset and a full-depth run.
module tb_instr_issuer;

  logic        ck = 1'b0;
  logic        clr_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [12:0] prog_data = '0;
  logic [3:0]  last = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [12:0] instr;
  logic        sel_en, alu_en, wr_stb, busy, done;
  logic [3:0]  pc;

  instr_issuer #(.DEPTH(16), .IW(13)) dut (
    .ck(ck), .clr_n(clr_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .last(last), .start(start), .abort(abort),
    .instr(instr), .sel_en(sel_en), .alu_en(alu_en), .wr_stb(wr_stb),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 ck = ~ck;

  localparam logic [12:0] A0 = 13'h000B;
  localparam logic [12:0] W0 = 13'h0811;
  localparam logic [12:0] W1 = 13'h1005;
  localparam logic [12:0] W2 = 13'h0A43;
  localparam logic [12:0] W3 = 13'h0126;
  localparam logic [12:0] HL = 13'h1801;

  int n_chk = 0;
  int n_pass = 0;

  // Packed output view: {sel_en, alu_en, wr_stb, busy, done, pc, instr}.
  logic [21:0] w_out;
  assign w_out = {sel_en, alu_en, wr_stb, busy, done, pc, instr};

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [12:0] data;
    logic [3:0]  last;
    logic        start;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [21:0] o(input logic s, input logic a, input logic w,
                                    input logic b, input logic d,
                                    input logic [3:0] p, input logic [12:0] i);
    return {s, a, w, b, d, p, i};
  endfunction
  function automatic logic [21:0] e_idl(input logic [3:0] p, input logic [12:0] i);
    return o(0, 0, 0, 0, 0, p, i);
  endfunction
  function automatic logic [21:0] e_set(input logic [3:0] p, input logic [12:0] i);
    return o(1, 1, 0, 1, 0, p, i);
  endfunction
  function automatic logic [21:0] e_stb(input logic [3:0] p, input logic [12:0] i);
    return o(1, 1, 1, 1, 0, p, i);
  endfunction
  function automatic logic [21:0] e_dn(input logic [3:0] p, input logic [12:0] i);
    return o(0, 0, 0, 0, 1, p, i);
  endfunction

  function automatic void wr_row(input logic [3:0] ad, input logic [12:0] d,
                                 input logic [21:0] e);
    vec_t v;
    v.we = 1'b1; v.addr = ad; v.data = d; v.last = '0; v.start = 1'b0; v.exp = e;
    tbl.push_back(v);
  endfunction
  function automatic void run_row(input logic [3:0] l, input logic s, input logic [21:0] e);
    vec_t v;
    v.we = 1'b0; v.addr = '0; v.data = '0; v.last = l; v.start = s; v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic pwrite(input logic [3:0] ad, input logic [12:0] d);
    prog_we = 1'b1; prog_addr = ad; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  initial begin
    int pulses, nbusy, bad_gap, last_pulse, cyc;
    bit hit;

    // Single instruction, last=0; start held into DONE then released.
    wr_row(0, A0, e_idl(0, 13'h0));
    run_row(0, 1, e_set(0, A0));
    run_row(0, 1, e_stb(0, A0));
    run_row(0, 1, e_set(0, A0));
    run_row(0, 1, e_dn(0, A0));
    run_row(0, 1, e_dn(0, A0));
    run_row(0, 0, e_idl(0, A0));
    run_row(0, 0, e_idl(0, A0));
    // Four instructions; last only sampled at start, start toggled mid-run.
    wr_row(0, W0, e_idl(0, A0));
    wr_row(1, W1, e_idl(0, A0));
    wr_row(2, W2, e_idl(0, A0));
    wr_row(3, W3, e_idl(0, A0));
    run_row(3, 1, e_set(0, W0));
    run_row(0, 1, e_stb(0, W0));
    run_row(0, 1, e_set(0, W0));
    run_row(0, 1, e_set(1, W1));
    run_row(0, 0, e_stb(1, W1));
    run_row(0, 1, e_set(1, W1));
    run_row(0, 1, e_set(2, W2));
    run_row(0, 1, e_stb(2, W2));
    run_row(0, 1, e_set(2, W2));
    run_row(0, 1, e_set(3, W3));
    run_row(0, 1, e_stb(3, W3));
    run_row(0, 1, e_set(3, W3));
    run_row(0, 1, e_dn(3, W3));
    run_row(0, 0, e_idl(3, W3));
    // HALT at entry 1 with last=3.
    wr_row(1, HL, e_idl(3, W3));
    run_row(3, 1, e_set(0, W0));
    run_row(3, 1, e_stb(0, W0));
    run_row(3, 1, e_set(0, W0));
    run_row(3, 1, e_set(1, HL));
    run_row(3, 1, e_dn(1, HL));
    run_row(3, 0, e_idl(1, HL));

    // Reset.
    clr_n = 1'b0;
    tick();
    tick();
    chk("reset", w_out, 22'h0);
    clr_n = 1'b1;

    foreach (tbl[i]) begin
      prog_we = tbl[i].we; prog_addr = tbl[i].addr; prog_data = tbl[i].data;
      last = tbl[i].last; start = tbl[i].start;
      tick();
      chk($sformatf("vec%0d", i), w_out, tbl[i].exp);
    end
    prog_we = 1'b0;

    // Abort during STROBE of entry 2.
    pwrite(1, W1);
    last = 3; start = 1'b1;
    pulses = 0; hit = 0;
    for (int c = 0; c < 30 && !hit; c++) begin
      tick();
      if (wr_stb) pulses++;
      if (wr_stb && pc == 2) hit = 1;
    end
    chk("abort_reach", 32'(hit), 32'd1);
    chk("abort_pulses", pulses, 3);
    abort = 1'b1;
    tick();
    chk("abort_idle", w_out, 22'h0);
    abort = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (wr_stb || busy) pulses++;
    end
    chk("abort_quiet", pulses, 0);
    start = 1'b0;
    tick();

    // Write while busy is ignored; then reset in HOLD.
    last = 0; start = 1'b1;
    tick();
    prog_we = 1'b1; prog_addr = 0; prog_data = 13'h1FFF;
    tick();
    tick();
    prog_we = 1'b0;
    tick();
    chk("we_busy_done", {done, busy}, 2'b10);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("we_busy_mem", instr, W0);
    tick();
    tick();
    chk("hold_state", {sel_en, wr_stb, busy}, 3'b101);
    clr_n = 1'b0; start = 1'b0;
    tick();
    chk("reset_hold", w_out, 22'h0);
    clr_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (wr_stb || busy) pulses++;
    end
    chk("reset_quiet", pulses, 0);
    start = 1'b1;
    tick();
    tick();
    chk("mem_keep", {wr_stb, instr}, {1'b1, W0});
    tick();
    tick();
    start = 1'b0;
    tick();

    // Full-depth run: last=15 ends after entry 15 without wrapping.
    for (int i = 0; i < 16; i++) pwrite(4'(i), 13'h0100 + 13'(i));
    last = 15; start = 1'b1;
    pulses = 0; nbusy = 0; bad_gap = 0; last_pulse = -1; hit = 0;
    for (cyc = 0; cyc < 80 && !hit; cyc++) begin
      tick();
      if (wr_stb) begin
        if (last_pulse >= 0 && cyc - last_pulse != 3) bad_gap++;
        last_pulse = cyc;
        pulses++;
      end
      if (busy) nbusy++;
      if (done) hit = 1;
    end
    chk("full_done", 32'(hit), 32'd1);
    chk("full_pulses", pulses, 16);
    chk("full_busy", nbusy, 48);
    chk("full_gap", bad_gap, 0);
    chk("full_end", {pc, instr}, {4'd15, 13'h010F});
    start = 1'b0;
    tick();
    chk("full_idle", {busy, done}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
